// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between the two packet sources, the arbiter and the downstream consumer.
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              in_0_valid;
  logic [DATA_W-1:0] in_0_data;
  logic              in_0_last;
  logic              in_0_ready;
  logic              in_1_valid;
  logic [DATA_W-1:0] in_1_data;
  logic              in_1_last;
  logic              in_1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              sel;
  logic              busy;
  logic              err_trunc;

  modport slave (
    input  in_0_valid, in_0_data, in_0_last,
    output in_0_ready,
    input  in_1_valid, in_1_data, in_1_last,
    output in_1_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output sel, busy, err_trunc
  );

  modport master (
    output in_0_valid, in_0_data, in_0_last,
    input  in_0_ready,
    output in_1_valid, in_1_data, in_1_last,
    input  in_1_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  sel, busy, err_trunc
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Packet-level round-robin arbiter for two sources sharing one registered output stage.
module mux2_rr_arbiter #(
  parameter int DATA_W      = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input logic              clk,
  input logic              rst_n,
  mux2_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                  state_q, state_d;
  logic                    last_served_q, last_served_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    sel_q, sel_d;
  logic                    out_valid_q, out_last_q, err_trunc_q;
  logic [DATA_W-1:0]       out_data_q;

  logic [1:0]              in_valid, in_last;
  logic [1:0][DATA_W-1:0]  in_data;
  logic                    gnt_src, granted, can_load, xfer, at_max, rel, trunc;

  assign in_valid = {bus.in_1_valid, bus.in_0_valid};
  assign in_last  = {bus.in_1_last,  bus.in_0_last};
  assign in_data  = {bus.in_1_data,  bus.in_0_data};

  assign gnt_src  = (state_q == GRANT1);
  assign granted  = (state_q == GRANT0) || (state_q == GRANT1);
  assign can_load = !out_valid_q || bus.out_ready;
  assign xfer     = granted && can_load && in_valid[gnt_src];
  // Beat number MAX_PKT_LEN is the one accepted while the count sits at MAX_PKT_LEN-1.
  assign at_max   = (beat_cnt_q == 8'(MAX_PKT_LEN - 1));
  assign rel      = xfer && (in_last[gnt_src] || at_max);
  assign trunc    = xfer && at_max && !in_last[gnt_src];

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (in_valid[0] && (!in_valid[1] || last_served_q)) state_d = GRANT0;
        else if (in_valid[1])                                state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (rel) begin
          last_served_d = gnt_src;
          beat_cnt_d    = '0;
          // Hand straight to the other source when it is waiting; no idle bubble.
          if (in_valid[~gnt_src]) state_d = gnt_src ? GRANT0 : GRANT1;
          else                    state_d = IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d = sel_q;
    if (state_d == GRANT0)      sel_d = 1'b0;
    else if (state_d == GRANT1) sel_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      sel_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      err_trunc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
      sel_q         <= sel_d;
      err_trunc_q   <= trunc;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[gnt_src];
        out_last_q  <= in_last[gnt_src] || at_max;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_0_ready = (state_q == GRANT0) && can_load;
  assign bus.in_1_ready = (state_q == GRANT1) && can_load;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = granted;
  assign bus.err_trunc  = err_trunc_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench: cycle table for arbitration/latency, then scoreboarded packet traffic for stall, truncation and reset.
module tb_mux2_rr_arbiter;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.DATA_W(DW)) bus ();

  mux2_rr_arbiter #(.DATA_W(DW), .MAX_PKT_LEN(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          rst;
    logic          v0;
    logic [DW-1:0] d0;
    logic          l0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          l1;
    logic          r0, r1, ov;
    logic [DW-1:0] od;
    logic          ol, sel, busy;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int checks = 0;
  int failures = 0;
  vec_t  vecs[14];
  beat_t s0_q[$], s1_q[$], exp_q[$];
  logic  sb_en = 1'b0;
  int    trunc_cnt = 0;
  logic [DW-1:0] trunc_data;
  logic  trunc_last;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rst, logic v0, logic [DW-1:0] d0, logic l0,
                              logic v1, logic [DW-1:0] d1, logic l1,
                              logic r0, logic r1, logic ov, logic [DW-1:0] od,
                              logic ol, logic sel, logic busy);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.ol = ol; v.sel = sel; v.busy = busy;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_0_valid = 1'b0; bus.in_1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_sel"},       bus.sel, 0);
    chk({tag, "_ready0"},    bus.in_0_ready, 0);
    chk({tag, "_ready1"},    bus.in_1_ready, 0);
    chk({tag, "_err"},       bus.err_trunc, 0);
    chk({tag, "_out_last"},  bus.out_last, 0);
  endtask

  task automatic drain(string name);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic feed0();
    logic fire;
    forever begin
      @(negedge clk);
      fire = bus.in_0_valid && bus.in_0_ready;
      @(posedge clk);
      #1;
      if (fire && s0_q.size() > 0) s0_q.delete(0);
      if (s0_q.size() > 0) begin
        bus.in_0_valid = 1'b1; bus.in_0_data = s0_q[0].data; bus.in_0_last = s0_q[0].last;
      end else bus.in_0_valid = 1'b0;
    end
  endtask

  task automatic feed1();
    logic fire;
    forever begin
      @(negedge clk);
      fire = bus.in_1_valid && bus.in_1_ready;
      @(posedge clk);
      #1;
      if (fire && s1_q.size() > 0) s1_q.delete(0);
      if (s1_q.size() > 0) begin
        bus.in_1_valid = 1'b1; bus.in_1_data = s1_q[0].data; bus.in_1_last = s1_q[0].last;
      end else bus.in_1_valid = 1'b0;
    end
  endtask

  task automatic push(logic src, logic [DW-1:0] d, logic l);
    beat_t b;
    b.data = d; b.last = l;
    if (src) s1_q.push_back(b); else s0_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Output monitor: pops the scoreboard on every consumed beat and records err_trunc pulses.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.err_trunc) begin
        trunc_cnt++;
        trunc_data = bus.out_data;
        trunc_last = bus.out_last;
      end
      if (sb_en && rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_beat", bus.out_data, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("sb_data", bus.out_data, e.data);
          chk("sb_last", bus.out_last, e.last);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Single 3-beat packet on in_0, then both sources with 2-beat packets from reset.
    vecs[0]  = mk(1, 1, 8'h11, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'h11, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0, 1);
    vecs[2]  = mk(0, 1, 8'h22, 0, 0, 8'h00, 0,  1, 0, 1, 8'h11, 0, 0, 1);
    vecs[3]  = mk(0, 1, 8'h33, 1, 0, 8'h00, 0,  1, 0, 1, 8'h22, 0, 0, 1);
    vecs[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 8'h33, 1, 0, 0);
    vecs[5]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 8'h33, 1, 0, 0);
    vecs[6]  = mk(1, 1, 8'hA0, 0, 1, 8'hC0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    vecs[7]  = mk(0, 1, 8'hA0, 0, 1, 8'hC0, 0,  1, 0, 0, 8'h00, 0, 0, 1);
    vecs[8]  = mk(0, 1, 8'hA1, 1, 1, 8'hC0, 0,  1, 0, 1, 8'hA0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 8'hB0, 0, 1, 8'hC0, 0,  0, 1, 1, 8'hA1, 1, 1, 1);
    vecs[10] = mk(0, 1, 8'hB0, 0, 1, 8'hC1, 1,  0, 1, 1, 8'hC0, 0, 1, 1);
    vecs[11] = mk(0, 1, 8'hB0, 0, 0, 8'h00, 0,  1, 0, 1, 8'hC1, 1, 0, 1);
    vecs[12] = mk(0, 1, 8'hB1, 1, 0, 8'h00, 0,  1, 0, 1, 8'hB0, 0, 0, 1);
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 8'hB1, 1, 0, 0);

    bus.in_0_valid = 0; bus.in_0_data = 0; bus.in_0_last = 0;
    bus.in_1_valid = 0; bus.in_1_data = 0; bus.in_1_last = 0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("por");

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      @(posedge clk);
      #1;
      bus.in_0_valid = vecs[i].v0; bus.in_0_data = vecs[i].d0; bus.in_0_last = vecs[i].l0;
      bus.in_1_valid = vecs[i].v1; bus.in_1_data = vecs[i].d1; bus.in_1_last = vecs[i].l1;
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i),    bus.in_0_ready, vecs[i].r0);
      chk($sformatf("v%0d_ready1", i),    bus.in_1_ready, vecs[i].r1);
      chk($sformatf("v%0d_out_valid", i), bus.out_valid,  vecs[i].ov);
      chk($sformatf("v%0d_out_data", i),  bus.out_data,   vecs[i].od);
      chk($sformatf("v%0d_out_last", i),  bus.out_last,   vecs[i].ol);
      chk($sformatf("v%0d_sel", i),       bus.sel,        vecs[i].sel);
      chk($sformatf("v%0d_busy", i),      bus.busy,       vecs[i].busy);
      chk($sformatf("v%0d_err", i),       bus.err_trunc,  0);
    end

    // Scoreboard phase: drivers pull beats from the source queues.
    fork
      feed0();
      feed1();
    join_none
    sb_en = 1'b1;

    // Backpressure for 4 cycles while 0xA5 sits in the output register.
    @(negedge clk);
    push(0, 8'h5A, 0); push(0, 8'hA5, 0); push(0, 8'hB6, 0); push(0, 8'hC7, 1);
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        @(negedge clk);
        if (bus.out_valid && bus.out_data == 8'h5A) break;
      end
      chk("stall_sync_timeout", (n < 50), 1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_data", k),   bus.out_data, 8'hA5);
      chk($sformatf("stall%0d_valid", k),  bus.out_valid, 1);
      chk($sformatf("stall%0d_ready0", k), bus.in_0_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain("stall_drain");

    // 20 beats without last on in_1 (last_served=0, so in_1 wins) with a 2-beat in_0 packet waiting.
    trunc_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) push(1, 8'(8'h80 + k), 0);
    exp_q[15].last = 1'b1;
    push(0, 8'h40, 0); push(0, 8'h41, 1);
    for (int k = 16; k < 20; k++) begin
      beat_t b;
      b.data = 8'(8'h80 + k); b.last = 1'b0;
      s1_q.push_back(b); exp_q.push_back(b);
    end
    drain("trunc_drain");
    chk("trunc_pulses", trunc_cnt, 1);
    chk("trunc_data", trunc_data, 8'h8F);
    chk("trunc_last", trunc_last, 1);
    @(negedge clk);
    chk("trunc_hold_busy", bus.busy, 1);
    chk("trunc_hold_sel", bus.sel, 1);

    // Async reset between edges while in_1 holds the grant with a beat in the output stage.
    sb_en = 1'b0;
    @(negedge clk);
    push(1, 8'h90, 0); push(1, 8'h91, 0); push(1, 8'h92, 0);
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        @(negedge clk);
        if (bus.out_valid) break;
      end
      chk("rst_sync_timeout", (n < 50), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    s0_q.delete(); s1_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;
    push(0, 8'h50, 1); push(1, 8'h60, 1);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
